mem_access: RTL and testbench

Memory-access stage of the RV32I core, between execute and writeback. Takes one load/store command per transaction from execute, issues it to the data cache over the `o_p_*` / `i_p_*` request/wait port, and handles the cache handshake. For loads it extracts, aligns and sign/zero-extends the returned data and presents it to writeback with the destination register. Stores get byte-lane replication and byte enables.

---
 rtl/mem_access.sv | 190 +++++++++++++++++++
 tb/tb_mem_access.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: RV32I memory-access stage. Issues one load/store per command to the
// data cache over a request/waitrequest port, then aligns and extends load data.
`default_nettype none

module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_req,
    input  logic        ex_mem_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_busy,
    output logic [31:0] o_p_addr,
    output logic        o_p_read,
    output logic        o_p_write,
    output logic [3:0]  o_p_byteenable,
    output logic [31:0] o_p_writedata,
    input  logic        i_p_waitrequest,
    input  logic [31:0] i_p_readdata,
    input  logic        i_p_readdata_valid,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        st_done,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic        read_q;
    logic        write_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        ld_valid_q;
    logic [31:0] ld_data_q;
    logic [4:0]  ld_rd_q;
    logic        st_done_q;
    logic        err_q;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // Command decode: legality (funct3 + alignment) and store lane steering
    always_comb begin
        w_legal = 1'b0;
        case ({ex_mem_we, ex_funct3})
            4'b0_000, 4'b0_100, 4'b1_000: w_legal = 1'b1;
            4'b0_001, 4'b0_101, 4'b1_001: w_legal = ~ex_addr[0];
            4'b0_010, 4'b1_010:           w_legal = (ex_addr[1:0] == 2'b00);
            default:                      w_legal = 1'b0;
        endcase

        w_be    = 4'b1111;
        w_wdata = ex_wdata;
        if (ex_mem_we) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ex_addr[1:0];
                    w_wdata = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << ex_addr[1:0];
                    w_wdata = {2{ex_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_wdata;
                end
            endcase
        end
    end

    // Load extraction from the raw cache word using the latched offset/funct3
    always_comb begin
        w_byte = 8'h00;
        case (off_q)
            2'd0: w_byte = i_p_readdata[7:0];
            2'd1: w_byte = i_p_readdata[15:8];
            2'd2: w_byte = i_p_readdata[23:16];
            2'd3: w_byte = i_p_readdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = off_q[1] ? i_p_readdata[31:16] : i_p_readdata[15:0];
        case (funct3_q)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = i_p_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
            ld_rd_q    <= 5'd0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_mem_req) begin
                        if (w_legal) begin
                            addr_q   <= {ex_addr[31:2], 2'b00};
                            funct3_q <= ex_funct3;
                            off_q    <= ex_addr[1:0];
                            rd_q     <= ex_rd;
                            be_q     <= w_be;
                            wdata_q  <= w_wdata;
                            read_q   <= ~ex_mem_we;
                            write_q  <= ex_mem_we;
                            state_q  <= S_REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (!i_p_waitrequest) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (write_q) begin
                            st_done_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else if (i_p_readdata_valid) begin
                            ld_valid_q <= 1'b1;
                            ld_data_q  <= w_ext;
                            ld_rd_q    <= rd_q;
                            state_q    <= S_IDLE;
                        end else begin
                            state_q <= S_RDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (i_p_readdata_valid) begin
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= w_ext;
                        ld_rd_q    <= rd_q;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_busy       = (state_q != S_IDLE);
    assign o_p_addr       = addr_q;
    assign o_p_read       = read_q;
    assign o_p_write      = write_q;
    assign o_p_byteenable = be_q;
    assign o_p_writedata  = wdata_q;
    assign ld_valid       = ld_valid_q;
    assign ld_data        = ld_data_q;
    assign ld_rd          = ld_rd_q;
    assign st_done        = st_done_q;
    assign mem_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: directed-vector bench for mem_access with hand-computed expectations.
`default_nettype none

module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        ex_mem_req;
    logic        ex_mem_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_busy;
    logic [31:0] o_p_addr;
    logic        o_p_read;
    logic        o_p_write;
    logic [3:0]  o_p_byteenable;
    logic [31:0] o_p_writedata;
    logic        i_p_waitrequest;
    logic [31:0] i_p_readdata;
    logic        i_p_readdata_valid;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        st_done;
    logic        mem_err;

    int n_vec = 0;
    int n_err = 0;
    int ld_pulses;

    mem_access dut (
        .clk                (clk),
        .rst                (rst),
        .ex_mem_req         (ex_mem_req),
        .ex_mem_we          (ex_mem_we),
        .ex_funct3          (ex_funct3),
        .ex_addr            (ex_addr),
        .ex_wdata           (ex_wdata),
        .ex_rd              (ex_rd),
        .mem_busy           (mem_busy),
        .o_p_addr           (o_p_addr),
        .o_p_read           (o_p_read),
        .o_p_write          (o_p_write),
        .o_p_byteenable     (o_p_byteenable),
        .o_p_writedata      (o_p_writedata),
        .i_p_waitrequest    (i_p_waitrequest),
        .i_p_readdata       (i_p_readdata),
        .i_p_readdata_valid (i_p_readdata_valid),
        .ld_valid           (ld_valid),
        .ld_data            (ld_data),
        .ld_rd              (ld_rd),
        .st_done            (st_done),
        .mem_err            (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, mem_busy}, 32'h0);
        chk({tag, "_addr"}, o_p_addr, 32'h0);
        chk({tag, "_rw"}, {30'h0, o_p_read, o_p_write}, 32'h0);
        chk({tag, "_be"}, {28'h0, o_p_byteenable}, 32'h0);
        chk({tag, "_wd"}, o_p_writedata, 32'h0);
        chk({tag, "_ldv"}, {31'h0, ld_valid}, 32'h0);
        chk({tag, "_ldd"}, ld_data, 32'h0);
        chk({tag, "_ldrd"}, {27'h0, ld_rd}, 32'h0);
        chk({tag, "_sterr"}, {30'h0, st_done, mem_err}, 32'h0);
    endtask

    // Zero-wait load: strobe now, request next cycle with data, result the cycle after.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        ex_mem_req = 1'b1; ex_mem_we = 1'b0; ex_funct3 = f3; ex_addr = addr; ex_rd = rd;
        i_p_waitrequest = 1'b0; i_p_readdata = rdata; i_p_readdata_valid = 1'b1;
        @(negedge clk);
        ex_mem_req = 1'b0;
        chk({tag, "_rd"}, {31'h0, o_p_read}, 32'h1);
        chk({tag, "_wr"}, {31'h0, o_p_write}, 32'h0);
        chk({tag, "_addr"}, o_p_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, {28'h0, o_p_byteenable}, 32'hF);
        chk({tag, "_busy"}, {31'h0, mem_busy}, 32'h1);
        @(negedge clk);
        i_p_readdata_valid = 1'b0;
        chk({tag, "_ldv"}, {31'h0, ld_valid}, 32'h1);
        chk({tag, "_data"}, ld_data, exp);
        chk({tag, "_ldrd"}, {27'h0, ld_rd}, {27'h0, rd});
        chk({tag, "_idle"}, {30'h0, mem_busy, o_p_read}, 32'h0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        ex_mem_req = 1'b1; ex_mem_we = 1'b1; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
        i_p_waitrequest = 1'b0;
        @(negedge clk);
        ex_mem_req = 1'b0;
        chk({tag, "_wr"}, {30'h0, o_p_write, o_p_read}, 32'h2);
        chk({tag, "_addr"}, o_p_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, {28'h0, o_p_byteenable}, {28'h0, exp_be});
        chk({tag, "_wd"}, o_p_writedata, exp_wd);
        @(negedge clk);
        chk({tag, "_done"}, {31'h0, st_done}, 32'h1);
        chk({tag, "_idle"}, {30'h0, mem_busy, o_p_write}, 32'h0);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
        ex_mem_req = 1'b1; ex_mem_we = we; ex_funct3 = f3; ex_addr = addr;
        @(negedge clk);
        ex_mem_req = 1'b0;
        chk({tag, "_err"}, {31'h0, mem_err}, 32'h1);
        chk({tag, "_quiet"}, {29'h0, mem_busy, o_p_read, o_p_write}, 32'h0);
        @(negedge clk);
        chk({tag, "_errclr"}, {31'h0, mem_err}, 32'h0);
        chk({tag, "_quiet2"}, {29'h0, mem_busy, o_p_read, o_p_write}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; ex_mem_req = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'b000;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
        i_p_waitrequest = 1'b0; i_p_readdata = 32'h0; i_p_readdata_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_load("lw100", 32'h0000_0100, 3'b010, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb103", 32'h0000_0103, 3'b000, 5'd6, 32'h8012_3456, 32'hFFFF_FF80);
        do_load("lbu103", 32'h0000_0103, 3'b100, 5'd7, 32'h8012_3456, 32'h0000_0080);
        do_load("lh102", 32'h0000_0102, 3'b001, 5'd8, 32'h7FFF_0000, 32'h0000_7FFF);
        do_load("lhu100", 32'h0000_0100, 3'b101, 5'd9, 32'h1234_ABCD, 32'h0000_ABCD);
        do_load("lb101", 32'h0000_0101, 3'b000, 5'd0, 32'h0000_7F00, 32'h0000_007F);

        // Store held under waitrequest for three cycles
        ex_mem_req = 1'b1; ex_mem_we = 1'b1; ex_funct3 = 3'b000;
        ex_addr = 32'h0000_0201; ex_wdata = 32'h0000_00AB; i_p_waitrequest = 1'b1;
        @(negedge clk);
        ex_mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) i_p_waitrequest = 1'b0;
            chk("sb_wr", {30'h0, o_p_write, o_p_read}, 32'h2);
            chk("sb_addr", o_p_addr, 32'h0000_0200);
            chk("sb_be", {28'h0, o_p_byteenable}, 32'h2);
            chk("sb_wd", o_p_writedata, 32'hABAB_ABAB);
            chk("sb_nodone", {31'h0, st_done}, 32'h0);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        chk("sb_done", {31'h0, st_done}, 32'h1);
        chk("sb_wrlow", {31'h0, o_p_write}, 32'h0);
        @(negedge clk);
        chk("sb_doneclr", {31'h0, st_done}, 32'h0);

        do_store("sh302", 32'h0000_0302, 3'b001, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);
        do_store("sw300", 32'h0000_0300, 3'b010, 32'h1122_3344, 4'b1111, 32'h1122_3344);
        do_store("sb003", 32'h0000_0003, 3'b000, 32'hFFFF_FF5A, 4'b1000, 32'h5A5A_5A5A);

        // Load that waits in RDATA; a strobe while busy must be ignored
        ld_pulses = 0;
        ex_mem_req = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0104; ex_rd = 5'd7; i_p_waitrequest = 1'b0; i_p_readdata_valid = 1'b0;
        @(negedge clk);
        ex_mem_req = 1'b0;
        chk("rdw_req", {31'h0, o_p_read}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ld_valid) ld_pulses++;
            chk("rdw_busy", {31'h0, mem_busy}, 32'h1);
            chk("rdw_rwlow", {30'h0, o_p_read, o_p_write}, 32'h0);
            if (i == 1) begin
                ex_mem_req = 1'b1; ex_mem_we = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0400;
            end else begin
                ex_mem_req = 1'b0;
            end
            if (i == 4) begin
                i_p_readdata = 32'h1234_5678; i_p_readdata_valid = 1'b1;
            end
        end
        @(negedge clk);
        i_p_readdata_valid = 1'b0;
        if (ld_valid) ld_pulses++;
        chk("rdw_data", ld_data, 32'h1234_5678);
        chk("rdw_ldrd", {27'h0, ld_rd}, 32'd7);
        @(negedge clk);
        if (ld_valid) ld_pulses++;
        chk("rdw_pulses", ld_pulses, 32'd1);
        chk("rdw_ignored", {29'h0, mem_busy, o_p_read, o_p_write}, 32'h0);

        do_err("lw102", 1'b0, 3'b010, 32'h0000_0102);
        do_err("sh301", 1'b1, 3'b001, 32'h0000_0301);
        do_err("f3_011", 1'b0, 3'b011, 32'h0000_0100);
        do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_0100);
        do_err("lhu103", 1'b0, 3'b101, 32'h0000_0103);

        // Reset while waiting in RDATA, then a late readdata_valid
        ex_mem_req = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0500; ex_rd = 5'd3; i_p_waitrequest = 1'b0; i_p_readdata_valid = 1'b0;
        @(negedge clk);
        ex_mem_req = 1'b0;
        @(negedge clk);
        chk("rst_inrdata", {31'h0, mem_busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0; i_p_readdata = 32'hCAFE_F00D; i_p_readdata_valid = 1'b1;
        @(negedge clk);
        i_p_readdata_valid = 1'b0;
        chk("rst_late_ldv", {31'h0, ld_valid}, 32'h0);
        chk("rst_late_busy", {31'h0, mem_busy}, 32'h0);
        chk("rst_late_ldd", ld_data, 32'h0);
        do_load("lw_after_rst", 32'h0000_0600, 3'b010, 5'd12, 32'h0BAD_F00D, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
